// File: rtl/mu_ring_arbiter.sv
// Motion-update migration ring arbiter: picks one packet per cycle from the upstream ring or the
// local MU buffer, returns it locally or forwards it downstream under credit control.
module mu_ring_arbiter #(
    parameter int PKT_WIDTH    = 32,
    parameter int MU_ID_WIDTH  = 4,
    parameter int LOCAL_MU_ID  = 0,
    parameter int STARVE_LIMIT = 8,
    parameter int CREDITS      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PKT_WIDTH-1:0] i_ring_pkt,
    input  logic                 i_ring_valid,
    output logic                 o_ring_ready,
    input  logic [PKT_WIDTH-1:0] i_buf_pkt,
    input  logic                 i_buf_valid,
    output logic                 o_buf_rden,
    output logic [PKT_WIDTH-1:0] o_ret_pkt,
    output logic                 o_ret_valid,
    output logic [PKT_WIDTH-1:0] o_fwd_pkt,
    output logic                 o_fwd_valid,
    input  logic                 i_credit_return,
    output logic [3:0]           o_credits,
    output logic                 o_credit_err,
    output logic [15:0]          o_fwd_count,
    output logic                 o_idle
);

    localparam logic [MU_ID_WIDTH-1:0] LOCAL_ID   = MU_ID_WIDTH'(LOCAL_MU_ID);
    localparam logic [7:0]             STARVE_MAX = 8'(STARVE_LIMIT - 1);
    localparam logic [3:0]             CREDIT_MAX = 4'(CREDITS);

    typedef enum logic {
        RING_PRIO = 1'b0,
        BUF_PRIO  = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [7:0]           starve_cnt;
    logic                 ring_local, buf_local;
    logic                 ring_elig, buf_elig;
    logic                 ring_gnt, buf_gnt;
    logic                 gnt_any, gnt_local, fwd_gnt, ret_gnt;
    logic [PKT_WIDTH-1:0] gnt_pkt;

    assign ring_local = (i_ring_pkt[PKT_WIDTH-1 -: MU_ID_WIDTH] == LOCAL_ID);
    assign buf_local  = (i_buf_pkt[PKT_WIDTH-1 -: MU_ID_WIDTH] == LOCAL_ID);
    // Local returns bypass the downstream buffer, so only forwards consume credits.
    assign ring_elig  = i_ring_valid & (ring_local | (o_credits != 4'd0));
    assign buf_elig   = i_buf_valid & (buf_local | (o_credits != 4'd0));

    always_comb begin
        state_next = state;
        ring_gnt   = 1'b0;
        buf_gnt    = 1'b0;
        case (state)
            RING_PRIO: begin
                if (ring_elig)
                    ring_gnt = 1'b1;
                else if (buf_elig)
                    buf_gnt = 1'b1;
                if (i_buf_valid && !buf_gnt && starve_cnt == STARVE_MAX)
                    state_next = BUF_PRIO;
            end
            BUF_PRIO: begin
                if (buf_elig)
                    buf_gnt = 1'b1;
                else if (ring_elig)
                    ring_gnt = 1'b1;
                if (buf_gnt)
                    state_next = RING_PRIO;
            end
            default: state_next = RING_PRIO;
        endcase
    end

    assign o_ring_ready = ring_gnt;
    assign o_buf_rden   = buf_gnt;
    assign gnt_any      = ring_gnt | buf_gnt;
    assign gnt_local    = ring_gnt ? ring_local : buf_local;
    assign gnt_pkt      = ring_gnt ? i_ring_pkt : i_buf_pkt;
    assign fwd_gnt      = gnt_any & ~gnt_local;
    assign ret_gnt      = gnt_any & gnt_local;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RING_PRIO;
            starve_cnt <= 8'd0;
        end else begin
            state <= state_next;
            if (!i_buf_valid || buf_gnt)
                starve_cnt <= 8'd0;
            else if (starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // Packet registers only load on a grant so they keep the last packet while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_ret_pkt   <= '0;
            o_ret_valid <= 1'b0;
            o_fwd_pkt   <= '0;
            o_fwd_valid <= 1'b0;
            o_fwd_count <= 16'd0;
        end else begin
            o_ret_valid <= ret_gnt;
            o_fwd_valid <= fwd_gnt;
            if (ret_gnt)
                o_ret_pkt <= gnt_pkt;
            if (fwd_gnt) begin
                o_fwd_pkt   <= gnt_pkt;
                o_fwd_count <= o_fwd_count + 16'd1;
            end
        end
    end

    // A forward is only granted with credits available, so the decrement cannot underflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_credits    <= CREDIT_MAX;
            o_credit_err <= 1'b0;
            o_idle       <= 1'b0;
        end else begin
            case ({fwd_gnt, i_credit_return})
                2'b10: o_credits <= o_credits - 4'd1;
                2'b01: begin
                    if (o_credits == CREDIT_MAX)
                        o_credit_err <= 1'b1;
                    else
                        o_credits <= o_credits + 4'd1;
                end
                default: o_credits <= o_credits;
            endcase
            o_idle <= ~i_ring_valid & ~i_buf_valid & (o_credits == CREDIT_MAX);
        end
    end

endmodule

// File: tb/tb_mu_ring_arbiter.sv
// Directed bench for mu_ring_arbiter: vector table for single-cycle behaviour plus hand-written
// sequences for local return, starvation, credit exhaustion, mid-stream reset and counter wrap.
module tb_mu_ring_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] i_ring_pkt;
    logic        i_ring_valid;
    logic        o_ring_ready;
    logic [31:0] i_buf_pkt;
    logic        i_buf_valid;
    logic        o_buf_rden;
    logic [31:0] o_ret_pkt;
    logic        o_ret_valid;
    logic [31:0] o_fwd_pkt;
    logic        o_fwd_valid;
    logic        i_credit_return;
    logic [3:0]  o_credits;
    logic        o_credit_err;
    logic [15:0] o_fwd_count;
    logic        o_idle;

    int errors = 0;
    int checks = 0;

    mu_ring_arbiter #(
        .PKT_WIDTH(32), .MU_ID_WIDTH(4), .LOCAL_MU_ID(0), .STARVE_LIMIT(8), .CREDITS(4)
    ) dut (
        .clk(clk), .rst(rst),
        .i_ring_pkt(i_ring_pkt), .i_ring_valid(i_ring_valid), .o_ring_ready(o_ring_ready),
        .i_buf_pkt(i_buf_pkt), .i_buf_valid(i_buf_valid), .o_buf_rden(o_buf_rden),
        .o_ret_pkt(o_ret_pkt), .o_ret_valid(o_ret_valid),
        .o_fwd_pkt(o_fwd_pkt), .o_fwd_valid(o_fwd_valid),
        .i_credit_return(i_credit_return), .o_credits(o_credits),
        .o_credit_err(o_credit_err), .o_fwd_count(o_fwd_count), .o_idle(o_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rv;
        logic [3:0] rdst;
        logic       bv;
        logic [3:0] bdst;
        logic       cr;
        logic       e_rr;
        logic       e_br;
        logic       e_ret;
        logic       e_fwd;
        logic [3:0] e_cred;
        logic       e_err;
        logic       e_idle;
    } vec_t;

    vec_t vecs [15];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; grants settle 1ns later, well before the next rising edge.
    task automatic applyStimulus(input logic rv, input logic [31:0] rp, input logic bv,
                                 input logic [31:0] bp, input logic cr);
        @(negedge clk);
        i_ring_valid    = rv;
        i_ring_pkt      = rp;
        i_buf_valid     = bv;
        i_buf_pkt       = bp;
        i_credit_return = cr;
        #1;
    endtask

    task automatic clearInputs();
        i_ring_valid    = 1'b0;
        i_buf_valid     = 1'b0;
        i_credit_return = 1'b0;
        i_ring_pkt      = '0;
        i_buf_pkt       = '0;
    endtask

    task automatic doReset();
        @(negedge clk);
        clearInputs();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [31:0] mkPkt(input logic [3:0] dst, input logic [27:0] payload);
        return {dst, payload};
    endfunction

    initial begin
        logic [31:0] rp, bp, exp_pkt;
        int          rr_cnt, ret_cnt, fwd_cnt, idx;
        logic [31:0] q [5];

        rst = 1'b0;
        clearInputs();

        //            rv  rdst  bv  bdst  cr  rr  br  ret fwd cred  err idle
        vecs[0]  = '{1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'd0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 4'd2, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0};

        #12;
        checkOutput("reset credits", 32'(o_credits), 32'd4);
        checkOutput("reset ret_valid", 32'(o_ret_valid), 32'd0);
        checkOutput("reset fwd_valid", 32'(o_fwd_valid), 32'd0);
        checkOutput("reset fwd_count", 32'(o_fwd_count), 32'd0);
        checkOutput("reset credit_err", 32'(o_credit_err), 32'd0);
        checkOutput("reset idle", 32'(o_idle), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 15; i++) begin
            rp = mkPkt(vecs[i].rdst, 28'hA000000 + 28'(i));
            bp = mkPkt(vecs[i].bdst, 28'hB000000 + 28'(i));
            applyStimulus(vecs[i].rv, rp, vecs[i].bv, bp, vecs[i].cr);
            checkOutput($sformatf("v%0d ring_ready", i), 32'(o_ring_ready), 32'(vecs[i].e_rr));
            checkOutput($sformatf("v%0d buf_rden", i), 32'(o_buf_rden), 32'(vecs[i].e_br));
            exp_pkt = vecs[i].e_rr ? rp : bp;
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d ret_valid", i), 32'(o_ret_valid), 32'(vecs[i].e_ret));
            checkOutput($sformatf("v%0d fwd_valid", i), 32'(o_fwd_valid), 32'(vecs[i].e_fwd));
            checkOutput($sformatf("v%0d credits", i), 32'(o_credits), 32'(vecs[i].e_cred));
            checkOutput($sformatf("v%0d credit_err", i), 32'(o_credit_err), 32'(vecs[i].e_err));
            checkOutput($sformatf("v%0d idle", i), 32'(o_idle), 32'(vecs[i].e_idle));
            if (vecs[i].e_ret)
                checkOutput($sformatf("v%0d ret_pkt", i), o_ret_pkt, exp_pkt);
            if (vecs[i].e_fwd)
                checkOutput($sformatf("v%0d fwd_pkt", i), o_fwd_pkt, exp_pkt);
        end
        @(negedge clk);
        clearInputs();
        checkOutput("table fwd_count", 32'(o_fwd_count), 32'd8);

        $display("[TB] local return only");
        doReset();
        rr_cnt  = 0;
        ret_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            rp = mkPkt(4'd0, 28'h0C00000 + 28'(i));
            applyStimulus(1'b1, rp, 1'b0, '0, 1'b0);
            if (o_ring_ready) rr_cnt++;
            @(posedge clk);
            #1;
            if (o_ret_valid) begin
                ret_cnt++;
                checkOutput($sformatf("local ret_pkt %0d", i), o_ret_pkt, rp);
            end
        end
        @(negedge clk);
        clearInputs();
        checkOutput("local ring_ready count", 32'(rr_cnt), 32'd20);
        checkOutput("local ret_valid count", 32'(ret_cnt), 32'd20);
        checkOutput("local credits", 32'(o_credits), 32'd4);
        checkOutput("local fwd_valid", 32'(o_fwd_valid), 32'd0);

        $display("[TB] starvation");
        doReset();
        for (int i = 1; i <= 27; i++) begin
            applyStimulus(1'b1, mkPkt(4'd5, 28'(i)), 1'b1, mkPkt(4'd6, 28'(i)), 1'b1);
            checkOutput($sformatf("starve c%0d buf_rden", i), 32'(o_buf_rden),
                        32'((i % 9) == 0));
            checkOutput($sformatf("starve c%0d ring_ready", i), 32'(o_ring_ready),
                        32'((i % 9) != 0));
        end
        @(negedge clk);
        clearInputs();
        checkOutput("starve credits", 32'(o_credits), 32'd4);
        checkOutput("starve credit_err", 32'(o_credit_err), 32'd0);

        $display("[TB] credit exhaustion");
        doReset();
        for (int i = 0; i < 5; i++) q[i] = mkPkt(4'd7, 28'h0E00000 + 28'(i));
        idx     = 0;
        fwd_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, q[idx], (i == 5), mkPkt(4'd0, 28'h0F00000), 1'b0);
            if (i == 4) checkOutput("exhaust stall ring_ready", 32'(o_ring_ready), 32'd0);
            if (i == 5) begin
                checkOutput("exhaust local buf_rden", 32'(o_buf_rden), 32'd1);
                checkOutput("exhaust local ring_ready", 32'(o_ring_ready), 32'd0);
            end
            if (o_ring_ready) idx++;
            @(posedge clk);
            #1;
            if (o_fwd_valid) fwd_cnt++;
        end
        checkOutput("exhaust fwd count", 32'(fwd_cnt), 32'd4);
        checkOutput("exhaust credits", 32'(o_credits), 32'd0);
        checkOutput("exhaust local ret_valid", 32'(o_ret_valid), 32'd1);
        applyStimulus(1'b1, q[idx], 1'b0, '0, 1'b1);
        checkOutput("exhaust return cycle ring_ready", 32'(o_ring_ready), 32'd0);
        applyStimulus(1'b1, q[idx], 1'b0, '0, 1'b0);
        checkOutput("exhaust 5th ring_ready", 32'(o_ring_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("exhaust 5th fwd_valid", 32'(o_fwd_valid), 32'd1);
        checkOutput("exhaust 5th fwd_pkt", o_fwd_pkt, q[4]);
        checkOutput("exhaust final credits", 32'(o_credits), 32'd0);

        $display("[TB] reset mid-stream");
        doReset();
        applyStimulus(1'b1, mkPkt(4'd9, 28'h0123456), 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("midrst pre fwd_valid", 32'(o_fwd_valid), 32'd1);
        #2;
        clearInputs();
        rst = 1'b0;
        #1;
        checkOutput("midrst fwd_valid", 32'(o_fwd_valid), 32'd0);
        checkOutput("midrst fwd_pkt", o_fwd_pkt, 32'd0);
        checkOutput("midrst credits", 32'(o_credits), 32'd4);
        checkOutput("midrst fwd_count", 32'(o_fwd_count), 32'd0);
        checkOutput("midrst ring_ready", 32'(o_ring_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst idle after release", 32'(o_idle), 32'd1);

        $display("[TB] fwd counter wrap");
        doReset();
        applyStimulus(1'b1, mkPkt(4'd3, 28'h0000777), 1'b0, '0, 1'b1);
        repeat (65537) @(posedge clk);
        @(negedge clk);
        clearInputs();
        checkOutput("wrap fwd_count", 32'(o_fwd_count), 32'd1);
        checkOutput("wrap credits", 32'(o_credits), 32'd4);
        checkOutput("wrap credit_err", 32'(o_credit_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
